// File: rtl/operand_buffer_pkg.sv
// Shared constants for the operand buffer: default store depths, FSM state
// encodings and the host opcode values used by the upstream decoder.
package operand_buffer_pkg;

    localparam int OB_DATA_W    = 8;
    localparam int OB_ADDR_W    = 4;
    localparam int OB_W_DEPTH   = 4;
    localparam int OB_INP_DEPTH = 4;
    localparam int OB_INS_DEPTH = 16;

    typedef logic [1:0] state_t;

    localparam state_t IDLE       = 2'd0;
    localparam state_t STREAM_W   = 2'd1;
    localparam state_t STREAM_INP = 2'd2;
    localparam state_t DONE       = 2'd3;

    localparam logic [2:0] OP_WEIGHT = 3'b001;
    localparam logic [2:0] OP_INPUT  = 3'b010;
    localparam logic [2:0] OP_INSTR  = 3'b011;
    localparam logic [2:0] OP_START  = 3'b100;

endpackage

// File: rtl/obuf_regfile.sv
// Small register-based store: synchronous write, asynchronous clear on reset,
// optional synchronous bulk clear, combinational read with range checks.
module obuf_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_oob,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  hit;
    logic              rd_oob;

    assign wr_oob = ({1'b0, wr_addr} >= (ADDR_W+1)'(DEPTH));
    assign rd_oob = ({1'b0, rd_addr} >= (ADDR_W+1)'(DEPTH));

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            assign hit[gi] = we && !wr_oob && (wr_addr == ADDR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clr)         mem_reg[i] <= '0;
                else if (hit[i]) mem_reg[i] <= wr_data;
            end
        end
    end

    // Out-of-range reads return zero instead of aliasing onto a real entry.
    assign rd_data = rd_oob ? '0 : mem_reg[rd_addr[IDX_W-1:0]];

endmodule

// File: rtl/operand_buffer.sv
// Operand buffer: captures host bytes into weight/input/instruction stores and
// streams weights then inputs to the array on a start edge.
// Build option OPBUF_SELFCLEAR_EN: clear weight and input stores on completion.
module operand_buffer
    import operand_buffer_pkg::*;
#(
    parameter int DATA_W    = OB_DATA_W,
    parameter int ADDR_W    = OB_ADDR_W,
    parameter int W_DEPTH   = OB_W_DEPTH,
    parameter int INP_DEPTH = OB_INP_DEPTH,
    parameter int INS_DEPTH = OB_INS_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fetch_w,
    input  logic              fetch_inp,
    input  logic              fetch_ins,
    input  logic              start,
    input  logic [ADDR_W-1:0] dma_address,
    input  logic [ADDR_W-1:0] ins_rd_addr,
    output logic [DATA_W-1:0] ins_rd_data,
    output logic [DATA_W-1:0] wt_out,
    output logic              wt_valid,
    output logic [DATA_W-1:0] inp_out,
    output logic              inp_valid,
    output logic              busy,
    output logic              done,
    output logic              addr_err
);

    localparam logic [ADDR_W-1:0] W_LAST   = ADDR_W'(W_DEPTH - 1);
    localparam logic [ADDR_W-1:0] INP_LAST = ADDR_W'(INP_DEPTH - 1);

    state_t            state_reg;
    logic              start_q_reg;
    logic [ADDR_W-1:0] idx_reg;
    logic [DATA_W-1:0] wt_out_reg, inp_out_reg, ins_rd_data_reg;
    logic              wt_valid_reg, inp_valid_reg, done_reg, addr_err_reg;

    logic              idle, busy_now, req, self_clr, wr_err;
    logic              sel_w, sel_inp, sel_ins;
    logic              w_oob, inp_oob, ins_oob;
    logic [DATA_W-1:0] w_rd, inp_rd, ins_rd;

    assign idle     = (state_reg == IDLE);
    assign busy_now = (state_reg == STREAM_W) || (state_reg == STREAM_INP);
    assign req      = start && !start_q_reg;

    assign sel_w   = fetch_w;
    assign sel_inp = !fetch_w && fetch_inp;
    assign sel_ins = !fetch_w && !fetch_inp && fetch_ins;

    // Writes outside IDLE are always dropped; only those during streaming flag an error.
    assign wr_err = idle ? ((sel_w && w_oob) || (sel_inp && inp_oob) || (sel_ins && ins_oob))
                         : (busy_now && (fetch_w || fetch_inp || fetch_ins));

`ifdef OPBUF_SELFCLEAR_EN
    assign self_clr = (state_reg == DONE);
`else
    assign self_clr = 1'b0;
`endif

    obuf_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(W_DEPTH)) u_wmem (
        .clk(clk), .reset(reset), .clr(self_clr), .we(idle && sel_w),
        .wr_addr(dma_address), .wr_data(data_in), .wr_oob(w_oob),
        .rd_addr(idx_reg), .rd_data(w_rd)
    );

    obuf_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(INP_DEPTH)) u_imem (
        .clk(clk), .reset(reset), .clr(self_clr), .we(idle && sel_inp),
        .wr_addr(dma_address), .wr_data(data_in), .wr_oob(inp_oob),
        .rd_addr(idx_reg), .rd_data(inp_rd)
    );

    obuf_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(INS_DEPTH)) u_insmem (
        .clk(clk), .reset(reset), .clr(1'b0), .we(idle && sel_ins),
        .wr_addr(dma_address), .wr_data(data_in), .wr_oob(ins_oob),
        .rd_addr(ins_rd_addr), .rd_data(ins_rd)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            start_q_reg     <= 1'b0;
            idx_reg         <= '0;
            wt_out_reg      <= '0;
            wt_valid_reg    <= 1'b0;
            inp_out_reg     <= '0;
            inp_valid_reg   <= 1'b0;
            done_reg        <= 1'b0;
            addr_err_reg    <= 1'b0;
            ins_rd_data_reg <= '0;
        end else begin
            start_q_reg     <= start;
            ins_rd_data_reg <= ins_rd;
            addr_err_reg    <= addr_err_reg || wr_err;
            wt_out_reg      <= '0;
            wt_valid_reg    <= 1'b0;
            inp_out_reg     <= '0;
            inp_valid_reg   <= 1'b0;
            done_reg        <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req) begin
                        state_reg <= STREAM_W;
                        idx_reg   <= '0;
                    end
                end
                STREAM_W: begin
                    wt_out_reg   <= w_rd;
                    wt_valid_reg <= 1'b1;
                    if (idx_reg == W_LAST) begin
                        idx_reg   <= '0;
                        state_reg <= STREAM_INP;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                STREAM_INP: begin
                    inp_out_reg   <= inp_rd;
                    inp_valid_reg <= 1'b1;
                    if (idx_reg == INP_LAST) begin
                        idx_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    done_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ins_rd_data = ins_rd_data_reg;
    assign wt_out      = wt_out_reg;
    assign wt_valid    = wt_valid_reg;
    assign inp_out     = inp_out_reg;
    assign inp_valid   = inp_valid_reg;
    assign busy        = busy_now;
    assign done        = done_reg;
    assign addr_err    = addr_err_reg;

endmodule

// File: tb/tb_operand_buffer.sv
// Directed self-checking bench for operand_buffer; expectations follow
// OPBUF_SELFCLEAR_EN when the bench is built with it defined.
module tb_operand_buffer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       fetch_w, fetch_inp, fetch_ins, start;
    logic [3:0] dma_address, ins_rd_addr;
    logic [7:0] ins_rd_data, wt_out, inp_out;
    logic       wt_valid, inp_valid, busy, done, addr_err;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    operand_buffer dut (
        .clk(clk), .reset(reset), .data_in(data_in),
        .fetch_w(fetch_w), .fetch_inp(fetch_inp), .fetch_ins(fetch_ins),
        .start(start), .dma_address(dma_address), .ins_rd_addr(ins_rd_addr),
        .ins_rd_data(ins_rd_data), .wt_out(wt_out), .wt_valid(wt_valid),
        .inp_out(inp_out), .inp_valid(inp_valid), .busy(busy), .done(done),
        .addr_err(addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int kind, input logic [3:0] addr, input logic [7:0] d);
        fetch_w     = (kind == 0);
        fetch_inp   = (kind == 1);
        fetch_ins   = (kind == 2);
        dma_address = addr;
        data_in     = d;
        @(negedge clk);
        fetch_w = 1'b0; fetch_inp = 1'b0; fetch_ins = 1'b0;
        $display("[TB] write kind=%0d addr=%0d data=%02h", kind, addr, d);
    endtask

    // Raises start on a negedge and watches 30 cycles of output.
    task automatic run_stream(input string name, input logic [7:0] ew[4], input logic [7:0] ei[4],
                              input int hold, input bit inject);
        int nw = 0, ni = 0, nd = 0, first_w = -1, first_i = -1, done_at = -1;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == hold) start = 1'b0;
            if (inject && c == 1) begin
                chk({name, " busy"}, 32'(busy), 32'd1);
                fetch_inp = 1'b1; dma_address = 4'd1; data_in = 8'h55;
            end
            if (inject && c == 2) fetch_inp = 1'b0;
            if (wt_valid) begin
                if (first_w < 0) first_w = c;
                if (nw < 4) chk($sformatf("%s wt[%0d]", name, nw), 32'(wt_out), 32'(ew[nw]));
                nw++;
            end else chk({name, " wt_out idle"}, 32'(wt_out), 32'd0);
            if (inp_valid) begin
                if (first_i < 0) first_i = c;
                if (ni < 4) chk($sformatf("%s inp[%0d]", name, ni), 32'(inp_out), 32'(ei[ni]));
                ni++;
            end else chk({name, " inp_out idle"}, 32'(inp_out), 32'd0);
            if (done) begin
                nd++;
                done_at = c;
            end
        end
        start = 1'b0;
        chk({name, " wt beats"}, 32'(nw), 32'd4);
        chk({name, " inp beats"}, 32'(ni), 32'd4);
        chk({name, " done pulses"}, 32'(nd), 32'd1);
        chk({name, " first wt cycle"}, 32'(first_w), 32'd2);
        chk({name, " first inp cycle"}, 32'(first_i), 32'd6);
        chk({name, " done cycle"}, 32'(done_at), 32'd10);
        $display("[TB] stream %s: wt=%0d inp=%0d done=%0d", name, nw, ni, nd);
    endtask

    initial begin
        logic [7:0] w_orig[4], i_orig[4], w_rep[4], i_rep[4], zeros[4];
        int nd;
        w_orig = '{8'h11, 8'h22, 8'h33, 8'h44};
        i_orig = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        zeros  = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef OPBUF_SELFCLEAR_EN
        w_rep = zeros;
        i_rep = zeros;
`else
        w_rep = w_orig;
        i_rep = i_orig;
`endif
        reset = 1'b0; data_in = '0; fetch_w = 0; fetch_inp = 0; fetch_ins = 0;
        start = 0; dma_address = '0; ins_rd_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst wt_valid", 32'(wt_valid), 0);
        chk("rst inp_valid", 32'(inp_valid), 0);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(done), 0);
        chk("rst addr_err", 32'(addr_err), 0);
        chk("rst ins_rd_data", 32'(ins_rd_data), 0);
        $display("[TB] reset checked");
        reset = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 4; a++) wr(0, 4'(a), w_orig[a]);
        for (int a = 0; a < 4; a++) wr(1, 4'(a), i_orig[a]);
        chk("no err after valid writes", 32'(addr_err), 0);

        // Write and read address 15 in the same cycle: old data first, new data next.
        ins_rd_addr = 4'd15;
        wr(2, 4'd15, 8'h9C);
        chk("ins same-cycle old", 32'(ins_rd_data), 32'h00);
        @(negedge clk);
        chk("ins read new", 32'(ins_rd_data), 32'h9C);
        $display("[TB] instr read 15 -> %02h", ins_rd_data);

        run_stream("s1", w_orig, i_orig, 1, 1'b0);
        run_stream("held", w_rep, i_rep, 20, 1'b0);
        chk("busy idle", 32'(busy), 0);

        wr(0, 4'd5, 8'h77);
        chk("oob write err", 32'(addr_err), 1);
        run_stream("inject", w_rep, i_rep, 1, 1'b1);
        run_stream("after inject", w_rep, i_rep, 1, 1'b0);
        chk("err sticky", 32'(addr_err), 1);
        chk("ins untouched", 32'(ins_rd_data), 32'h9C);

        // Abort mid STREAM_INP with an asynchronous reset.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid inp_valid", 32'(inp_valid), 1);
        reset = 1'b0;
        #1;
        chk("abort wt_valid", 32'(wt_valid), 0);
        chk("abort wt_out", 32'(wt_out), 0);
        chk("abort inp_valid", 32'(inp_valid), 0);
        chk("abort inp_out", 32'(inp_out), 0);
        chk("abort busy", 32'(busy), 0);
        chk("abort addr_err", 32'(addr_err), 0);
        chk("abort ins_rd_data", 32'(ins_rd_data), 0);
        nd = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort no done", 32'(nd), 0);
        $display("[TB] reset abort done_pulses=%0d", nd);
        reset = 1'b1;
        @(negedge clk);
        chk("ins cleared", 32'(ins_rd_data), 0);
        run_stream("post reset", zeros, zeros, 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
